// File: rtl/console_mailbox_pkg.sv
// Shared definitions for the console mailbox: register offsets, STATUS bit
// positions and the UART transmitter state encoding.
package console_mailbox_pkg;

    // Byte offsets of the register window
    localparam int unsigned REG_TXDATA  = 0;
    localparam int unsigned REG_STATUS  = 4;
    localparam int unsigned REG_EXIT    = 8;
    localparam int unsigned REG_SCRATCH = 12;

    // STATUS register layout
    localparam int unsigned STAT_FULL      = 0;
    localparam int unsigned STAT_EMPTY     = 1;
    localparam int unsigned STAT_BUSY      = 2;
    localparam int unsigned STAT_DONE      = 3;
    localparam int unsigned STAT_COUNT_LSB = 8;

    // UART transmitter states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter with a byte valid/ready input.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   byte_valid      a byte is offered on byte_data
//   byte_data[7:0]  byte to send
//   byte_ready_c    byte taken this cycle when byte_valid is also high
//   tx              serial output, idle high
//   busy            a frame is in progress
module uart_tx_serializer
    import console_mailbox_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready_c,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_e         state_q, state_n;
    logic [BAUD_W-1:0] cnt_q, cnt_n;
    logic [2:0]        bit_q, bit_n;
    logic [7:0]        sh_q, sh_n;
    logic              tx_n;
    logic              busy_n;

    // Next-state logic; tx is computed one cycle ahead so the line is registered
    always_comb begin
        state_n      = state_q;
        cnt_n        = cnt_q;
        bit_n        = bit_q;
        sh_n         = sh_q;
        tx_n         = tx;
        byte_ready_c = 1'b0;
        case (state_q)
            IDLE: begin
                byte_ready_c = 1'b1;
                tx_n         = 1'b1;
                if (byte_valid) begin
                    sh_n    = byte_data;
                    cnt_n   = RELOAD;
                    state_n = START;
                    tx_n    = 1'b0;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    state_n = DATA;
                    cnt_n   = RELOAD;
                    bit_n   = 3'd0;
                    tx_n    = sh_q[0];
                end else begin
                    cnt_n = cnt_q - BAUD_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    cnt_n = RELOAD;
                    if (bit_q == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_n = bit_q + 3'd1;
                        sh_n  = {1'b0, sh_q[7:1]};
                        tx_n  = sh_q[1];
                    end
                end else begin
                    cnt_n = cnt_q - BAUD_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    // Last stop cycle doubles as the IDLE check: no gap between frames
                    byte_ready_c = 1'b1;
                    if (byte_valid) begin
                        sh_n    = byte_data;
                        cnt_n   = RELOAD;
                        state_n = START;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                    end
                end else begin
                    cnt_n = cnt_q - BAUD_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            sh_q    <= 8'd0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            bit_q   <= bit_n;
            sh_q    <= sh_n;
            tx      <= tx_n;
            busy    <= busy_n;
        end
    end

endmodule

// File: rtl/console_mailbox.sv
// Memory-mapped console/exit mailbox: buffers characters in a FIFO, sends
// them out on a UART line and latches the end-of-test exit code.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req_valid/req_ready    request handshake (accept on valid & ready)
//   req_write              1 = write, 0 = read
//   req_addr[ADDR_W-1:0]   byte address
//   req_wdata[31:0]        write data
//   req_wstrb[3:0]         byte enables
//   rsp_valid              one-cycle pulse the cycle after each accept
//   rsp_rdata[31:0]        read data (0 for writes and errors)
//   rsp_err                unmapped, misaligned or write-to-STATUS
//   uart_tx                serial output, idle high
//   done, exit_code        sticky end-of-test flag and its value
module console_mailbox
    import console_mailbox_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned ADDR_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              uart_tx,
    output logic              done,
    output logic [31:0]       exit_code
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_n;
    logic             full_q;
    logic             empty_c;
    logic [31:0]      scratch_q, scratch_n;
    logic             done_n;
    logic [31:0]      exit_n;

    logic             hit_tx, hit_st, hit_ex, hit_sc;
    logic             accept_c, err_c, push_c, pop_c;
    logic [31:0]      rdata_c, status_c;
    logic             byte_ready_c;
    logic             tx_busy;

    // Only a TXDATA write into a full FIFO is back-pressured
    assign req_ready = !(req_valid && req_write && hit_tx && full_q);
    assign empty_c   = (count_q == '0);
    assign pop_c     = byte_ready_c && !empty_c;

    // Decode, read mux and register updates
    always_comb begin
        hit_tx    = (req_addr == ADDR_W'(REG_TXDATA));
        hit_st    = (req_addr == ADDR_W'(REG_STATUS));
        hit_ex    = (req_addr == ADDR_W'(REG_EXIT));
        hit_sc    = (req_addr == ADDR_W'(REG_SCRATCH));
        accept_c  = req_valid && req_ready;
        // Misaligned addresses match no register, so they fall into the error case
        err_c     = !(hit_tx || hit_st || hit_ex || hit_sc) || (req_write && hit_st);

        status_c                           = 32'd0;
        status_c[STAT_FULL]                = full_q;
        status_c[STAT_EMPTY]               = empty_c;
        status_c[STAT_BUSY]                = tx_busy;
        status_c[STAT_DONE]                = done;
        status_c[STAT_COUNT_LSB +: 8]      = 8'(count_q);

        rdata_c = 32'd0;
        if (!req_write && !err_c) begin
            if (hit_st) rdata_c = status_c;
            if (hit_ex) rdata_c = exit_code;
            if (hit_sc) rdata_c = scratch_q;
        end

        push_c    = accept_c && req_write && hit_tx && req_wstrb[0];
        done_n    = done;
        exit_n    = exit_code;
        scratch_n = scratch_q;
        if (accept_c && req_write && !err_c) begin
            if (hit_ex && (req_wstrb == 4'hF) && !done) begin
                done_n = 1'b1;
                exit_n = req_wdata;
            end
            if (hit_sc) begin
                for (int b = 0; b < 4; b++) begin
                    if (req_wstrb[b]) scratch_n[8*b +: 8] = req_wdata[8*b +: 8];
                end
            end
        end

        count_n = count_q;
        if (push_c && !pop_c)      count_n = count_q + CNT_W'(1);
        else if (!push_c && pop_c) count_n = count_q - CNT_W'(1);
    end

    // Control and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            done      <= 1'b0;
            exit_code <= 32'd0;
            scratch_q <= 32'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
        end else begin
            rsp_valid <= accept_c;
            rsp_rdata <= accept_c ? rdata_c : 32'd0;
            rsp_err   <= accept_c && err_c;
            done      <= done_n;
            exit_code <= exit_n;
            scratch_q <= scratch_n;
            if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q   <= count_n;
            full_q    <= (count_n == CNT_W'(FIFO_DEPTH));
        end
    end

    // Character storage; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (push_c) fifo_mem[wr_ptr_q] <= req_wdata[7:0];
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_ser (
        .clk          (clk),
        .rst          (rst),
        .byte_valid   (!empty_c),
        .byte_data    (fifo_mem[rd_ptr_q]),
        .byte_ready_c (byte_ready_c),
        .tx           (uart_tx),
        .busy         (tx_busy)
    );

endmodule

// File: tb/tb_console_mailbox.sv
// Directed bench for console_mailbox with a fast baud rate.
module tb_console_mailbox;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [3:0]  req_addr = 4'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  req_wstrb = 4'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        uart_tx;
    logic        done;
    logic [31:0] exit_code;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rsp_cnt = 0;
    int low_cnt = 0;

    logic [7:0] mon_bytes[$];
    int         mon_start[$];
    bit         mon_stop[$];

    console_mailbox #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (16),
        .ADDR_W       (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .uart_tx   (uart_tx),
        .done      (done),
        .exit_code (exit_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rsp_valid === 1'b1) rsp_cnt <= rsp_cnt + 1;
    end

    always @(negedge clk) begin
        if (uart_tx === 1'b0) low_cnt <= low_cnt + 1;
    end

    // UART receiver: samples each bit one cycle into its period
    initial begin : uart_mon
        logic [7:0] b;
        int s;
        b = 8'h00;
        forever begin
            @(negedge clk);
            if (uart_tx === 1'b0) begin
                s = cyc;
                repeat (CPB + 1) @(negedge clk);
                b[0] = uart_tx;
                for (int i = 1; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (CPB) @(negedge clk);
                mon_stop.push_back(uart_tx === 1'b1);
                mon_bytes.push_back(b);
                mon_start.push_back(s);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    // One accepted request; returns just after the accept edge
    task automatic bus_req(input logic w, input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s, output int waits);
        waits     = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        @(negedge clk);
        while (req_ready !== 1'b1 && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bus_req_timeout addr=%h ready=%b required 1", a, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 4'h0;
        req_wdata = 32'h0;
        req_wstrb = 4'h0;
    endtask

    // Request plus capture of its response
    task automatic do_xfer(input logic w, input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd,
                           output logic er, output logic vld);
        int wt;
        bus_req(w, a, d, s, wt);
        @(negedge clk);
        vld = rsp_valid;
        rd  = rsp_rdata;
        er  = rsp_err;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic er, vld;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_uart_tx got=%b exp=1", uart_tx); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (exit_code !== 32'h0) begin errors++; $display("FAIL reset_exit_code got=%h exp=0", exit_code); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        @(posedge clk);
        #1;
        do_xfer(1'b0, 4'h4, 32'h0, 4'h0, rd, er, vld);
        checks++; if (vld !== 1'b1 || er !== 1'b0 || rd !== 32'h0000_0002) begin
            errors++; $display("FAIL reset_status got vld=%b err=%b rdata=%h exp 1/0/00000002", vld, er, rd);
        end
    endtask

    task automatic test_tx_frame();
        logic [7:0] ch;
        logic exp_tx;
        logic [31:0] rd;
        logic er, vld;
        int wt;
        ch = 8'h41;
        mon_bytes.delete(); mon_start.delete(); mon_stop.delete();
        bus_req(1'b1, 4'h0, {24'h0, ch}, 4'h1, wt);
        for (int k = 0; k < 42; k++) begin
            if (k > 0) @(posedge clk);
            @(negedge clk);
            if (k == 0)       exp_tx = 1'b1;
            else if (k <= 4)  exp_tx = 1'b0;
            else if (k <= 36) exp_tx = ch[(k - 5) / 4];
            else              exp_tx = 1'b1;
            checks++;
            if (uart_tx !== exp_tx) begin
                errors++; $display("FAIL frame_bit cycle=%0d got=%b exp=%b", k, uart_tx, exp_tx);
            end
        end
        @(posedge clk);
        #1;
        do_xfer(1'b0, 4'h4, 32'h0, 4'h0, rd, er, vld);
        checks++; if (rd !== 32'h0000_0002) begin errors++; $display("FAIL frame_status got=%h exp=00000002", rd); end
        checks++; if (mon_bytes.size() != 1 || mon_bytes[0] !== 8'h41) begin
            errors++; $display("FAIL frame_rx count=%0d exp 1 byte 41", mon_bytes.size());
        end
    endtask

    task automatic test_fifo_stall();
        int wt, max_wt, t, base;
        logic [31:0] rd;
        logic er, vld;
        mon_bytes.delete(); mon_start.delete(); mon_stop.delete();
        base   = rsp_cnt;
        max_wt = 0;
        for (int i = 0; i < 18; i++) begin
            bus_req(1'b1, 4'h0, 32'(i), 4'h1, wt);
            if (i < 17 && wt > max_wt) max_wt = wt;
            if (i == 17) begin
                checks++; if (wt != 25) begin errors++; $display("FAIL stall_cycles got=%0d exp=25", wt); end
            end
        end
        checks++; if (max_wt != 0) begin errors++; $display("FAIL early_stall got=%0d exp=0", max_wt); end
        t = 0;
        while (mon_bytes.size() < 18 && t < 1500) begin
            @(posedge clk);
            t++;
        end
        checks++; if (mon_bytes.size() != 18) begin errors++; $display("FAIL rx_count got=%0d exp=18", mon_bytes.size()); end
        for (int i = 0; i < mon_bytes.size(); i++) begin
            checks++; if (mon_bytes[i] !== 8'(i) || !mon_stop[i]) begin
                errors++; $display("FAIL rx_byte idx=%0d got=%h stop=%0d exp=%h stop=1", i, mon_bytes[i], mon_stop[i], 8'(i));
            end
            if (i > 0) begin
                checks++; if (mon_start[i] - mon_start[i-1] != 40) begin
                    errors++; $display("FAIL frame_gap idx=%0d got=%0d exp=40", i, mon_start[i] - mon_start[i-1]);
                end
            end
        end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (rsp_cnt - base != 18) begin errors++; $display("FAIL push_rsp_count got=%0d exp=18", rsp_cnt - base); end
        do_xfer(1'b0, 4'h4, 32'h0, 4'h0, rd, er, vld);
        checks++; if (rd !== 32'h0000_0002) begin errors++; $display("FAIL drained_status got=%h exp=00000002", rd); end
    endtask

    task automatic test_exit();
        logic [31:0] rd;
        logic er, vld;
        do_xfer(1'b1, 4'h8, 32'hFFFF_FFFF, 4'h1, rd, er, vld);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL exit_partial_strobe done got=%b exp=0", done); end
        do_xfer(1'b1, 4'h8, 32'h0000_0000, 4'hF, rd, er, vld);
        checks++; if (done !== 1'b1 || exit_code !== 32'h0) begin
            errors++; $display("FAIL exit_set got done=%b code=%h exp 1/00000000", done, exit_code);
        end
        do_xfer(1'b1, 4'h8, 32'hDEAD_BEEF, 4'hF, rd, er, vld);
        checks++; if (er !== 1'b0 || done !== 1'b1 || exit_code !== 32'h0) begin
            errors++; $display("FAIL exit_sticky got err=%b done=%b code=%h exp 0/1/00000000", er, done, exit_code);
        end
        do_xfer(1'b0, 4'h8, 32'h0, 4'h0, rd, er, vld);
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL exit_read got=%h err=%b exp=00000000/0", rd, er); end
        do_xfer(1'b0, 4'h4, 32'h0, 4'h0, rd, er, vld);
        checks++; if (rd !== 32'h0000_000A) begin errors++; $display("FAIL exit_status got=%h exp=0000000a", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic er, vld;
        do_xfer(1'b0, 4'h6, 32'h0, 4'h0, rd, er, vld);
        checks++; if (vld !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL misaligned_read got vld=%b err=%b rdata=%h exp 1/1/0", vld, er, rd);
        end
        do_xfer(1'b1, 4'h4, 32'hFFFF_FFFF, 4'hF, rd, er, vld);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL status_write got err=%b rdata=%h exp 1/0", er, rd); end
        do_xfer(1'b1, 4'hC, 32'h1234_5678, 4'b0011, rd, er, vld);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL scratch_write err got=%b exp=0", er); end
        do_xfer(1'b0, 4'hC, 32'h0, 4'h0, rd, er, vld);
        checks++; if (rd !== 32'h0000_5678) begin errors++; $display("FAIL scratch_strobe got=%h exp=00005678", rd); end
        do_xfer(1'b1, 4'hD, 32'hFFFF_FFFF, 4'hF, rd, er, vld);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL misaligned_write err got=%b exp=1", er); end
        do_xfer(1'b0, 4'hC, 32'h0, 4'h0, rd, er, vld);
        checks++; if (rd !== 32'h0000_5678) begin errors++; $display("FAIL scratch_unchanged got=%h exp=00005678", rd); end
        do_xfer(1'b1, 4'h1, 32'h0000_0033, 4'hF, rd, er, vld);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL misaligned_txdata err got=%b exp=1", er); end
        do_xfer(1'b0, 4'h4, 32'h0, 4'h0, rd, er, vld);
        checks++; if (rd !== 32'h0000_000A) begin errors++; $display("FAIL no_push_status got=%h exp=0000000a", rd); end
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'hC; req_wdata = 32'hCAFE_F00D; req_wstrb = 4'hF;
        @(posedge clk); #1;
        req_write = 1'b0; req_addr = 4'h6; req_wdata = 32'h0; req_wstrb = 4'h0;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL b2b_rsp0 got vld=%b err=%b rdata=%h exp 1/0/0", rsp_valid, rsp_err, rsp_rdata);
        end
        @(posedge clk); #1;
        req_addr = 4'hC;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL b2b_rsp1 got vld=%b err=%b rdata=%h exp 1/1/0", rsp_valid, rsp_err, rsp_rdata);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = 4'h0;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL b2b_rsp2 got vld=%b err=%b rdata=%h exp 1/0/cafef00d", rsp_valid, rsp_err, rsp_rdata);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_pulse got=%b exp=0", rsp_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midframe();
        int wt, base;
        logic [31:0] rd;
        logic er, vld;
        bus_req(1'b1, 4'h0, 32'h55, 4'h1, wt);
        bus_req(1'b1, 4'h0, 32'h01, 4'h1, wt);
        bus_req(1'b1, 4'h0, 32'h02, 4'h1, wt);
        bus_req(1'b1, 4'h0, 32'h03, 4'h1, wt);
        repeat (15) @(posedge clk);
        #1;
        checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL midframe_bit3 got=%b exp=0", uart_tx); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_line_high got=%b exp=1", uart_tx); end
        @(posedge clk); #1;
        rst = 1'b0;
        base = low_cnt;
        do_xfer(1'b0, 4'h4, 32'h0, 4'h0, rd, er, vld);
        checks++; if (rd !== 32'h0000_0002) begin errors++; $display("FAIL post_reset_status got=%h exp=00000002", rd); end
        checks++; if (done !== 1'b0 || exit_code !== 32'h0) begin
            errors++; $display("FAIL post_reset_done got done=%b code=%h exp 0/0", done, exit_code);
        end
        repeat (100) @(posedge clk);
        #1;
        checks++; if (low_cnt != base) begin errors++; $display("FAIL frames_after_reset low_cycles got=%0d exp=0", low_cnt - base); end
    endtask

    initial begin : main
        test_reset();
        test_tx_frame();
        test_fifo_stall();
        test_exit();
        test_errors();
        test_back_to_back();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
